// File: rtl/aes_key_pkg.sv
// rtl/aes_key_pkg.sv - shared types and constants for the AES key-schedule units
package aes_key_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, SUB, DONE} key_state_e;

  localparam int CNT_W         = 5;
  localparam int KEY_BYTES     = 16;
  localparam int STREAM_CYCLES = 16;
  localparam int SUB_CYCLES    = 4;

  localparam logic [7:0] RCON_LAST     = 8'h36;
  localparam logic [7:0] INV_RCON_POLY = 8'h8D;

  // Inverse of the xtime step: halve in GF(2^8), folding the reduction polynomial back in
  function automatic logic [7:0] inv_rcon_next(input logic [7:0] rc);
    return rc[0] ? ((rc >> 1) ^ INV_RCON_POLY) : (rc >> 1);
  endfunction

endpackage

// File: rtl/inv_rcon_gen.sv
// rtl/inv_rcon_gen.sv - inverse round-constant register: load to the last Rcon, step backwards
module inv_rcon_gen
  import aes_key_pkg::*;
#(
  parameter logic [7:0] P_RCON_INIT = aes_key_pkg::RCON_LAST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_step,
  output logic [7:0] o_rcon
);

  logic [7:0] r_rcon;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcon <= P_RCON_INIT;
    end else if (i_load) begin
      r_rcon <= P_RCON_INIT;
    end else if (i_step) begin
      r_rcon <= inv_rcon_next(r_rcon);
    end
  end

  assign o_rcon = r_rcon;

endmodule

// File: rtl/inv_key_registers_unit.sv
// rtl/inv_key_registers_unit.sv - byte-serial AES-128 inverse key schedule
// Streams the held round key byte by byte while rewinding it to the previous round key.
module inv_key_registers_unit
  import aes_key_pkg::*;
#(
  parameter int         NR        = 10,
  parameter logic [7:0] RCON_LAST = aes_key_pkg::RCON_LAST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in_valid,
  input  logic [7:0] key_in,
  input  logic       start,
  input  logic [7:0] sbox_out,
  output logic [7:0] key_out,
  output logic       key_out_valid,
  output logic       sbox_req,
  output logic [7:0] sbox_in,
  output logic       busy,
  output logic       loaded,
  output logic       done,
  output logic [3:0] round_idx
);

  localparam logic [3:0]       LP_NR          = 4'(NR);
  localparam logic [CNT_W-1:0] LP_LOAD_LAST   = CNT_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0] LP_STREAM_LAST = CNT_W'(STREAM_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_SUB_LAST    = CNT_W'(STREAM_CYCLES + SUB_CYCLES - 1);

  key_state_e       r_state;
  key_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_key  [KEY_BYTES];
  logic [7:0]       r_hist [4];
  logic [7:0]       r_key_hold;
  logic             r_loaded;
  logic [3:0]       r_round;

  logic       w_load_byte;
  logic       w_load_last;
  logic       w_start_ok;
  logic [1:0] w_sub_sel;
  logic [3:0] w_sbox_idx;
  logic [7:0] w_rcon;
  logic [7:0] w_rcon_mix;

  assign w_load_byte = key_in_valid && ((r_state == IDLE) || (r_state == LOAD));
  assign w_load_last = key_in_valid && (r_state == LOAD) && (r_cnt == LP_LOAD_LAST);
  assign w_start_ok  = start && r_loaded && (r_round != 4'd0) && (r_state == IDLE) && !key_in_valid;

  // SUB step s updates byte s from the RotWord'd last word: 13, 14, 15, 12
  assign w_sub_sel  = r_cnt[1:0];
  assign w_sbox_idx = {2'b11, w_sub_sel + 2'd1};
  assign w_rcon_mix = (w_sub_sel == 2'd0) ? w_rcon : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (key_in_valid) begin
          w_next = LOAD;
        end else if (w_start_ok) begin
          w_next = STREAM;
        end
      end
      LOAD:    if (w_load_last) w_next = IDLE;
      STREAM:  if (r_cnt == LP_STREAM_LAST) w_next = SUB;
      SUB:     if (r_cnt == LP_SUB_LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_loaded <= 1'b0;
      r_round  <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (key_in_valid) begin
            r_cnt    <= CNT_W'(1);
            r_loaded <= 1'b0;
          end else if (w_start_ok) begin
            r_cnt <= '0;
          end
        end
        LOAD: begin
          if (key_in_valid) r_cnt <= r_cnt + CNT_W'(1);
          if (w_load_last) begin
            r_loaded <= 1'b1;
            r_round  <= LP_NR;
          end
        end
        STREAM, SUB: r_cnt <= r_cnt + CNT_W'(1);
        DONE: begin
          r_cnt   <= '0;
          r_round <= r_round - 4'd1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // STREAM rotates the register through K0; the last four original bytes are kept
  // in r_hist because the in-place XOR needs k(j-4) before it was overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KEY_BYTES; i++) r_key[i] <= 8'h00;
      for (int i = 0; i < 4; i++) r_hist[i] <= 8'h00;
      r_key_hold <= 8'h00;
    end else if (w_load_byte) begin
      for (int i = 0; i < KEY_BYTES - 1; i++) r_key[i] <= r_key[i+1];
      r_key[KEY_BYTES-1] <= key_in;
    end else if (r_state == STREAM) begin
      for (int i = 0; i < KEY_BYTES - 1; i++) r_key[i] <= r_key[i+1];
      r_key[KEY_BYTES-1] <= (r_cnt < CNT_W'(4)) ? r_key[0] : (r_key[0] ^ r_hist[3]);
      r_hist[0]  <= r_key[0];
      r_hist[1]  <= r_hist[0];
      r_hist[2]  <= r_hist[1];
      r_hist[3]  <= r_hist[2];
      r_key_hold <= r_key[0];
    end else if (r_state == SUB) begin
      r_key[{2'b00, w_sub_sel}] <= r_key[{2'b00, w_sub_sel}] ^ sbox_out ^ w_rcon_mix;
    end
  end

  inv_rcon_gen #(
    .P_RCON_INIT (RCON_LAST)
  ) u_inv_rcon_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load_last),
    .i_step (r_state == DONE),
    .o_rcon (w_rcon)
  );

  assign key_out_valid = (r_state == STREAM);
  assign key_out       = key_out_valid ? r_key[0] : r_key_hold;
  assign sbox_req      = (r_state == SUB);
  assign sbox_in       = sbox_req ? r_key[w_sbox_idx] : 8'h00;
  assign busy          = (r_state == STREAM) || (r_state == SUB);
  assign done          = (r_state == DONE);
  assign loaded        = r_loaded;
  assign round_idx     = r_round;

endmodule

// File: tb/tb_inv_key_registers_unit.sv
// tb/tb_inv_key_registers_unit.sv - self-checking bench for inv_key_registers_unit
module tb_inv_key_registers_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_in_valid = 1'b0;
  logic [7:0] key_in = 8'h00;
  logic       start = 1'b0;
  logic [7:0] sbox_out;
  logic [7:0] key_out;
  logic       key_out_valid;
  logic       sbox_req;
  logic [7:0] sbox_in;
  logic       busy;
  logic       loaded;
  logic       done;
  logic [3:0] round_idx;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_key [16];
  logic [3:0] m_round;
  logic [7:0] got   [16];

  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [7:0] fips_last [16] = '{8'hd0, 8'h14, 8'hf9, 8'ha8, 8'hc9, 8'hee, 8'h25, 8'h89,
                                 8'he1, 8'h3f, 8'h0c, 8'hc8, 8'hb6, 8'h63, 8'h0c, 8'ha6};
  logic [7:0] fips_r9 [16]   = '{8'hac, 8'h77, 8'h66, 8'hf3, 8'h19, 8'hfa, 8'hdc, 8'h21,
                                 8'h28, 8'hd1, 8'h29, 8'h41, 8'h57, 8'h5c, 8'h00, 8'h6e};
  logic [7:0] fips_r1 [16]   = '{8'ha0, 8'hfa, 8'hfe, 8'h17, 8'h88, 8'h54, 8'h2c, 8'hb1,
                                 8'h23, 8'ha3, 8'h39, 8'h39, 8'h2a, 8'h6c, 8'h76, 8'h05};

  inv_key_registers_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_in_valid  (key_in_valid),
    .key_in        (key_in),
    .start         (start),
    .sbox_out      (sbox_out),
    .key_out       (key_out),
    .key_out_valid (key_out_valid),
    .sbox_req      (sbox_req),
    .sbox_in       (sbox_in),
    .busy          (busy),
    .loaded        (loaded),
    .done          (done),
    .round_idx     (round_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // AES S-box from its definition: multiplicative inverse then affine map
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign sbox_out = sbox_f(sbox_in);

  // Previous round key: w3..w1 undo the chained XOR, w0 undoes SubWord(RotWord(w3'))^Rcon
  task automatic model_step();
    logic [7:0] p [16];
    p = m_key;
    for (int j = 4; j < 16; j++) p[j] = m_key[j] ^ m_key[j-4];
    p[0] = m_key[0] ^ sbox_f(p[13]) ^ rcon_tab[m_round - 4'd1];
    p[1] = m_key[1] ^ sbox_f(p[14]);
    p[2] = m_key[2] ^ sbox_f(p[15]);
    p[3] = m_key[3] ^ sbox_f(p[12]);
    m_key   = p;
    m_round = m_round - 4'd1;
  endtask

  task automatic load_key(input logic [7:0] k [16], input int gap);
    for (int i = 0; i < 16; i++) begin
      repeat (gap) begin
        key_in_valid = 1'b0;
        key_in = 8'($urandom);
        @(negedge clk);
      end
      key_in_valid = 1'b1;
      key_in = k[i];
      @(negedge clk);
      n_tests++;
      if (loaded !== (i == 15)) begin
        $display("FAIL load_flag byte=%0d got %b exp %b", i, loaded, (i == 15));
        n_fail++;
      end
    end
    key_in_valid = 1'b0;
    m_key = k;
    m_round = 4'd10;
    n_tests++;
    if (round_idx !== 4'd10) begin
      $display("FAIL load_round got %0d exp 10", round_idx);
      n_fail++;
    end
  endtask

  // Called at a negedge with the unit idle; leaves at the negedge of the cycle after DONE
  task automatic run_round(input bit disturb);
    logic [7:0] prev [16];
    logic [7:0] exp_sb [4];
    prev = m_key;
    for (int j = 4; j < 16; j++) prev[j] = m_key[j] ^ m_key[j-4];
    exp_sb = '{prev[13], prev[14], prev[15], prev[12]};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c < 16) begin
        got[c] = key_out;
        n_tests++;
        if (key_out_valid !== 1'b1 || key_out !== m_key[c] || sbox_req !== 1'b0) begin
          $display("FAIL stream c=%0d got %h v=%b req=%b exp %h", c, key_out, key_out_valid, sbox_req, m_key[c]);
          n_fail++;
        end
      end else if (c < 20) begin
        n_tests++;
        if (sbox_req !== 1'b1 || sbox_in !== exp_sb[c-16] || key_out_valid !== 1'b0 || key_out !== m_key[15]) begin
          $display("FAIL sub c=%0d got req=%b in=%h v=%b out=%h exp in=%h out=%h",
                   c, sbox_req, sbox_in, key_out_valid, key_out, exp_sb[c-16], m_key[15]);
          n_fail++;
        end
      end else begin
        n_tests++;
        if (sbox_req !== 1'b0 || sbox_in !== 8'h00) begin
          $display("FAIL sbox_idle got req=%b in=%h exp 0/00", sbox_req, sbox_in);
          n_fail++;
        end
      end
      n_tests++;
      if (busy !== (c < 20) || done !== (c == 20)) begin
        $display("FAIL timing c=%0d got busy=%b done=%b exp busy=%b done=%b", c, busy, done, (c < 20), (c == 20));
        n_fail++;
      end
      if (disturb && c < 20) begin
        start = 1'($urandom);
        key_in_valid = 1'($urandom);
        key_in = 8'($urandom);
      end else begin
        start = 1'b0;
        key_in_valid = 1'b0;
      end
      @(negedge clk);
    end
    model_step();
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || round_idx !== m_round || loaded !== 1'b1) begin
      $display("FAIL after_round got done=%b busy=%b idx=%0d loaded=%b exp 0/0/%0d/1", done, busy, round_idx, loaded, m_round);
      n_fail++;
    end
  endtask

  task automatic check_idle_start(input string name);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (busy !== 1'b0 || key_out_valid !== 1'b0 || sbox_req !== 1'b0) begin
        $display("FAIL %s c=%0d got busy=%b v=%b req=%b exp 0", name, c, busy, key_out_valid, sbox_req);
        n_fail++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({key_out, key_out_valid, sbox_req, sbox_in, busy, loaded, done, round_idx} !== 29'd0) begin
      $display("FAIL reset got out=%h v=%b req=%b in=%h busy=%b ld=%b done=%b idx=%0d exp all 0",
               key_out, key_out_valid, sbox_req, sbox_in, busy, loaded, done, round_idx);
      n_fail++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_start("reset_start");
  endtask

  task automatic test_ten_rounds();
    int bad;
    load_key(fips_last, 0);
    for (int r = 0; r < 10; r++) begin
      run_round(1'b0);
      if (r == 1 || r == 9) begin
        bad = 0;
        for (int i = 0; i < 16; i++) begin
          if (r == 1 && got[i] !== fips_r9[i]) bad++;
          if (r == 9 && got[i] !== fips_r1[i]) bad++;
        end
        n_tests++;
        if (bad != 0) begin
          $display("FAIL fips_stream round=%0d got %h%h%h%h... bad=%0d exp 0", r, got[0], got[1], got[2], got[3], bad);
          n_fail++;
        end
      end
    end
    n_tests++;
    if (round_idx !== 4'd0) begin
      $display("FAIL final_idx got %0d exp 0", round_idx);
      n_fail++;
    end
    check_idle_start("eleventh_start");
  endtask

  task automatic test_busy_ignore();
    load_key(fips_last, 0);
    run_round(1'b1);
    run_round(1'b1);
    run_round(1'b0);
  endtask

  task automatic test_reset_mid();
    load_key(fips_last, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({key_out, key_out_valid, sbox_req, sbox_in, busy, loaded, done, round_idx} !== 29'd0) begin
      $display("FAIL mid_reset got out=%h v=%b req=%b in=%h busy=%b ld=%b done=%b idx=%0d exp all 0",
               key_out, key_out_valid, sbox_req, sbox_in, busy, loaded, done, round_idx);
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_start("start_after_reset");
  endtask

  task automatic test_gap_load();
    logic [7:0] k [16];
    for (int i = 0; i < 16; i++) k[i] = 8'($urandom);
    load_key(k, 2);
    run_round(1'b0);
    run_round(1'b0);
  endtask

  task automatic test_random_keys();
    logic [7:0] k [16];
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 16; i++) k[i] = 8'($urandom);
      load_key(k, int'($urandom_range(0, 1)));
      for (int r = 0; r < 10; r++) run_round(r[0]);
      check_idle_start("exhausted_start");
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ten_rounds();
    test_busy_ignore();
    test_reset_mid();
    test_gap_load();
    test_random_keys();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inv_key_registers_unit.md
Name: inv_key_registers_unit

Overview:
- Byte-serial AES-128 inverse key-schedule unit for the decryption datapath; the counterpart of the forward byte-serial key register unit.
- Loaded once with the last round key, it streams each round key out byte-serially.
- While streaming, it rewinds the schedule in place to the previous round key, using the shared external S-box through a request/response port.
- Sits between the key-load interface and the inverse AddRoundKey stage of the decryption core.

Parameters:
- NR, 10, number of AES rounds. Sets the round-counter load value; only 10 (AES-128) is supported.
- RCON_LAST, 8'h36, Rcon of the final round, loaded into the inverse Rcon register.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- key_in_valid  in  1  one key byte present on key_in this cycle
- key_in  in  8  last-round-key byte, k0 first
- start  in  1  single-cycle pulse: emit the current round key and rewind one round
- sbox_out  in  8  shared S-box result, combinational from sbox_in
- key_out  out  8  current round-key byte
- key_out_valid  out  1  key_out qualifier
- sbox_req  out  1  unit owns the shared S-box this cycle
- sbox_in  out  8  S-box operand
- busy  out  1  ROUND operation in progress
- loaded  out  1  16 key bytes received
- done  out  1  single-cycle pulse after each ROUND
- round_idx  out  4  index of the round key currently held (NR..0)

Behaviour:
- Reset values: key_out=0, key_out_valid=0, sbox_req=0, sbox_in=0, busy=0, loaded=0, done=0, round_idx=0. The 16 key bytes reset to 0; rcon resets to RCON_LAST.
- Key store: 16x8 shift register K0..K15, shifting toward K0; new bytes enter at K15.
- FSM states: IDLE, LOAD, STREAM, SUB, DONE.
- IDLE→LOAD: first key_in_valid while not busy.
- LOAD: each key_in_valid shifts key_in in. Gaps are allowed and hold state.
- LOAD, 16th byte: loaded=1, round_idx=NR, rcon=RCON_LAST, return to IDLE.
- key_in_valid while loaded=1 and not busy restarts LOAD: clears loaded and begins a new 16-byte count.
- IDLE→STREAM: start && loaded && round_idx!=0.
- start ignored when round_idx==0, when not loaded, or while busy.
- STREAM, cycles 0..15:
  - key_out = current k_j, j=0..15 in order; key_out_valid=1.
  - Simultaneously, bytes 4..15 are replaced by k_j ^ k_(j-4), forming w1'..w3'.
  - Bytes 0..3 are retained unchanged.
- SUB, cycles 16..19:
  - sbox_req=1; sbox_in = k13', k14', k15', k12' in that order (RotWord).
  - k0'=k0^S(k13')^rcon, k1'=k1^S(k14'), k2'=k2^S(k15'), k3'=k3^S(k12').
- DONE, cycle 20: done=1 for one cycle, busy drops, round_idx decrements. Inverse Rcon update: rcon = rcon[0] ? (rcon>>1)^8'h8D : rcon>>1, so 36→1B→80→40→…→01.
- busy is high for exactly cycles 0..19. ROUND latency is start→done = 21 cycles.
- key_out holds its last value when key_out_valid=0. sbox_in is 0 when sbox_req=0.
- key_in_valid while busy is ignored: no shift, no LOAD restart.
- rst_n low at any time, including mid-STREAM/SUB: immediate clear to reset values. The partial key is discarded, loaded=0, and a reload is required.
- Wrap-around: after round_idx reaches 0 the register holds the cipher key. Further start pulses are ignored until a new LOAD.

Decomposition:
- Shared package aes_key_pkg contains:
  - state enum {IDLE, LOAD, STREAM, SUB, DONE}
  - STREAM_CYCLES=16, SUB_CYCLES=4
  - RCON_LAST=8'h36, INV_RCON_POLY=8'h8D
  - 5-bit cycle-counter width
- One natural sub-module: inv_rcon_gen (rcon register with load/step/reset), reused by the future AES-192/256 variant.

Test Plan:
- FIPS-197 A.1 load: bytes d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6 → loaded=1, round_idx=10.
- One start → key_out streams d014f9a8…0ca6 over 16 cycles; sbox_req for 4 cycles; done at start+21; register holds ac7766f319fadc2128d12941575c006e; round_idx=9.
- Ten consecutive rounds → round-9 key streamed as ac77…006e; round-1 key a0fafe17…2a6c7605 streamed on round 10; final register 2b7e151628aed2a6abf7158809cf4f3c; round_idx=0; an eleventh start produces no busy.
- start while busy, and key_in_valid while busy → no effect; same done timing and key as the undisturbed run.
- rst_n asserted at STREAM cycle 7 → all outputs 0 in the same cycle; loaded=0; a subsequent start is ignored.
- key_in_valid with gaps (valid every 3rd cycle) → load completes after exactly 16 valid bytes with a correct register image.
